// File: rtl/pool_pkg.sv
// Shared mode encodings and width helpers for the 2x2 pooling stage.
package pool_pkg;

    localparam logic [1:0] POOL_BYPASS = 2'd0;
    localparam logic [1:0] POOL_MAX    = 2'd1;
    localparam logic [1:0] POOL_AVG    = 2'd2;

    function automatic int cfg_width_bits(input int maxw);
        return $clog2(maxw) + 1;
    endfunction

    // A MAXW of 2 still needs a one-bit line-buffer address.
    function automatic int lbuf_addr_bits(input int maxw);
        return (maxw > 2) ? $clog2(maxw / 2) : 1;
    endfunction

endpackage

// File: rtl/pool_pe.sv
// One-channel combiner: max of two values, or their sum widened by one bit.
module pool_pe
    import pool_pkg::*;
#(
    parameter int DW     = 8,
    parameter int SIGNED = 1
) (
    input  logic [1:0]  mode,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW:0]   result
);

    logic [DW:0] a_ext;
    logic [DW:0] b_ext;
    logic        a_gt;

    assign a_ext  = {(SIGNED != 0) && a[DW-1], a};
    assign b_ext  = {(SIGNED != 0) && b[DW-1], b};
    assign a_gt   = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
    assign result = (mode == POOL_MAX) ? (a_gt ? a_ext : b_ext) : (a_ext + b_ext);

endmodule

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 / stride-2 pooling stage (max, avg, bypass) with ready/valid
// on both sides and a line buffer holding the horizontal results of even rows.
module pool2x2_stream
    import pool_pkg::*;
#(
    parameter int DW     = 8,
    parameter int DN     = 6,
    parameter int MAXW   = 64,
    parameter int SIGNED = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [cfg_width_bits(MAXW)-1:0] cfg_width,
    input  logic [1:0]                      cfg_mode,
    input  logic                            frame_clr,
    input  logic [DN*DW-1:0]                m_data,
    input  logic                            m_valid,
    output logic                            m_ready,
    output logic [DN*DW-1:0]                s_data,
    output logic                            s_valid,
    input  logic                            s_ready
);

    localparam int CW  = cfg_width_bits(MAXW);
    localparam int AW  = lbuf_addr_bits(MAXW);
    localparam int LBD = 1 << AW;
    localparam int HW  = DW + 1;

    logic [CW-1:0]    col;
    logic             row_ph;
    logic [DN*DW-1:0] h_reg;
    logic [DN*HW-1:0] lbuf [LBD];
    logic [DN*HW-1:0] lb_rd;
    logic [DN*HW-1:0] h_sum;
    logic [DN*DW-1:0] v_out;
    logic [AW-1:0]    lb_idx;
    logic             accept;
    logic             last_col;
    logic             odd_col;
    logic             pooling;
    logic             emit_pool;

    assign m_ready   = !frame_clr && (!s_valid || s_ready);
    assign accept    = m_valid && m_ready;
    assign last_col  = (col == cfg_width - CW'(1));
    assign odd_col   = col[0];
    assign pooling   = (cfg_mode == POOL_MAX) || (cfg_mode == POOL_AVG);
    assign emit_pool = accept && pooling && odd_col && row_ph;
    assign lb_idx    = col[AW:1];
    assign lb_rd     = lbuf[lb_idx];

    for (genvar ch = 0; ch < DN; ch++) begin : g_ch
        logic [DW+1:0] v_res;

        pool_pe #(.DW(DW), .SIGNED(SIGNED)) u_pe_h (
            .mode   (cfg_mode),
            .a      (h_reg[ch*DW +: DW]),
            .b      (m_data[ch*DW +: DW]),
            .result (h_sum[ch*HW +: HW])
        );

        pool_pe #(.DW(HW), .SIGNED(SIGNED)) u_pe_v (
            .mode   (cfg_mode),
            .a      (lb_rd[ch*HW +: HW]),
            .b      (h_sum[ch*HW +: HW]),
            .result (v_res)
        );

        // Dropping the two LSBs of the 4-pixel sum is the floor divide by 4.
        assign v_out[ch*DW +: DW] = (cfg_mode == POOL_MAX) ? v_res[DW-1:0] : v_res[DW+1:2];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || frame_clr) begin
            col    <= '0;
            row_ph <= 1'b0;
            h_reg  <= '0;
        end else if (accept) begin
            col <= last_col ? '0 : col + CW'(1);
            if (last_col) begin
                row_ph <= !row_ph;
            end
            // An even-column last pixel only occurs for odd widths and is dropped.
            if (!odd_col && !last_col) begin
                h_reg <= m_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && accept && pooling && odd_col && !row_ph) begin
            lbuf[lb_idx] <= h_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_valid <= 1'b0;
            s_data  <= '0;
        end else if (accept && !pooling) begin
            s_valid <= 1'b1;
            s_data  <= m_data;
        end else if (emit_pool) begin
            s_valid <= 1'b1;
            s_data  <= v_out;
        end else if (s_ready) begin
            s_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench for pool2x2_stream: max/avg/bypass results, latency,
// backpressure, odd width, frame_clr and mid-frame reset.
module tb_pool2x2_stream;
    import pool_pkg::*;

    localparam int DW   = 8;
    localparam int DN   = 6;
    localparam int MAXW = 64;
    localparam int CW   = cfg_width_bits(MAXW);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CW-1:0]    cfg_width;
    logic [1:0]       cfg_mode;
    logic             frame_clr;
    logic [DN*DW-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [DN*DW-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    int checks = 0;
    int errors = 0;
    logic [DN*DW-1:0] out_q[$];
    logic             tog_stop;

    pool2x2_stream #(.DW(DW), .DN(DN), .MAXW(MAXW), .SIGNED(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_width (cfg_width),
        .cfg_mode  (cfg_mode),
        .frame_clr (frame_clr),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready)
    );

    always #5 clk = !clk;

    always @(posedge clk) begin
        if (rst_n && s_valid && s_ready) out_q.push_back(s_data);
    end

    function automatic logic [DN*DW-1:0] px(input int v);
        logic [DW-1:0] b;
        b = DW'(v);
        return {DN{b}};
    endfunction

    function automatic logic [DN*DW-1:0] beat(input int k);
        logic [DN*DW-1:0] d;
        for (int c = 0; c < DN; c++) d[c*DW +: DW] = DW'(k * 16 + c);
        return d;
    endfunction

    task automatic send_beat(input logic [DN*DW-1:0] d);
        int n;
        n = 0;
        m_data  = d;
        m_valid = 1'b1;
        @(negedge clk);
        while (!m_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!m_ready) begin
            checks++;
            errors++;
            $display("FAIL send_beat_timeout: m_ready=%0b required 1", m_ready);
        end
        @(posedge clk);
        #1;
        m_valid = 1'b0;
    endtask

    task automatic do_clr();
        frame_clr = 1'b1;
        @(posedge clk);
        #1;
        frame_clr = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        m_valid = 1'b1;
        m_data  = px(7);
        cfg_mode  = POOL_BYPASS;
        cfg_width = CW'(4);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_s_valid: got %0b required 0", s_valid);
        end
        checks++;
        if (s_data !== '0) begin
            errors++;
            $display("FAIL reset_s_data: got %h required 0", s_data);
        end
        m_valid = 1'b0;
        rst_n   = 1'b1;
        drain();
        checks++;
        if (out_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_no_output: got %0d beats required 0", out_q.size());
        end
        out_q.delete();
    endtask

    task automatic test_max();
        int row1[4] = '{1, 5, 2, 3};
        int row2[4] = '{4, 0, 9, -7};
        int expv[4] = '{0, 5, 0, 9};
        do_clr();
        cfg_mode  = POOL_MAX;
        cfg_width = CW'(4);
        foreach (row1[i]) begin
            send_beat(px(row1[i]));
            checks++;
            if (s_valid !== 1'b0) begin
                errors++;
                $display("FAIL max_row1_quiet: beat %0d s_valid=%0b required 0", i, s_valid);
            end
        end
        foreach (row2[i]) begin
            send_beat(px(row2[i]));
            checks++;
            if (s_valid !== (expv[i] != 0)) begin
                errors++;
                $display("FAIL max_row2_valid: beat %0d s_valid=%0b required %0b", i, s_valid, expv[i] != 0);
            end else if (s_valid && s_data !== px(expv[i])) begin
                errors++;
                $display("FAIL max_row2_data: beat %0d got %h required %h", i, s_data, px(expv[i]));
            end
        end
        drain();
        checks++;
        if (out_q.size() !== 2) begin
            errors++;
            $display("FAIL max_count: got %0d required 2", out_q.size());
        end
        out_q.delete();
    endtask

    task automatic test_avg();
        int vals[8] = '{1, 5, 2, 3, 4, 0, 9, -7};
        do_clr();
        cfg_mode  = POOL_AVG;
        cfg_width = CW'(4);
        foreach (vals[i]) send_beat(px(vals[i]));
        drain();
        checks++;
        if (out_q.size() !== 2) begin
            errors++;
            $display("FAIL avg_count: got %0d required 2", out_q.size());
        end else begin
            checks++;
            if (out_q[0] !== px(2) || out_q[1] !== px(1)) begin
                errors++;
                $display("FAIL avg_data: got %h %h required %h %h", out_q[0], out_q[1], px(2), px(1));
            end
        end
        out_q.delete();
        do_clr();
        cfg_width = CW'(2);
        send_beat(px(-1));
        send_beat(px(-2));
        send_beat(px(-3));
        send_beat(px(-4));
        checks++;
        if (s_valid !== 1'b1 || s_data !== px(-3)) begin
            errors++;
            $display("FAIL avg_floor: valid=%0b data=%h required 1 %h", s_valid, s_data, px(-3));
        end
        drain();
        out_q.delete();
    endtask

    task automatic test_backpressure();
        do_clr();
        cfg_mode  = POOL_MAX;
        cfg_width = CW'(4);
        s_ready   = 1'b1;
        send_beat(px(1));
        send_beat(px(5));
        send_beat(px(2));
        send_beat(px(3));
        send_beat(px(4));
        send_beat(px(0));
        s_ready = 1'b0;
        fork
            send_beat(px(9));
            begin
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if (s_valid !== 1'b1 || s_data !== px(5) || m_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_hold: valid=%0b data=%h m_ready=%0b required 1 %h 0",
                                 s_valid, s_data, m_ready, px(5));
                    end
                end
                s_ready = 1'b1;
            end
        join
        send_beat(px(-7));
        drain();
        checks++;
        if (out_q.size() !== 2) begin
            errors++;
            $display("FAIL bp_count: got %0d required 2", out_q.size());
        end else begin
            checks++;
            if (out_q[0] !== px(5) || out_q[1] !== px(9)) begin
                errors++;
                $display("FAIL bp_data: got %h %h required %h %h", out_q[0], out_q[1], px(5), px(9));
            end
        end
        out_q.delete();
    endtask

    task automatic test_odd_width();
        int vals[10] = '{1, 2, 3, 4, 99, 5, 6, 7, 8, 99};
        do_clr();
        cfg_mode  = POOL_MAX;
        cfg_width = CW'(5);
        foreach (vals[i]) send_beat(px(vals[i]));
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL odd_discard_quiet: s_valid=%0b required 0", s_valid);
        end
        drain();
        checks++;
        if (out_q.size() !== 2) begin
            errors++;
            $display("FAIL odd_count: got %0d required 2", out_q.size());
        end else begin
            checks++;
            if (out_q[0] !== px(6) || out_q[1] !== px(8)) begin
                errors++;
                $display("FAIL odd_data: got %h %h required %h %h", out_q[0], out_q[1], px(6), px(8));
            end
        end
        out_q.delete();
    endtask

    task automatic test_frame_clr();
        int vals[7] = '{1, 5, 2, 3, 4, 0, 9};
        do_clr();
        cfg_mode  = POOL_MAX;
        cfg_width = CW'(4);
        foreach (vals[i]) send_beat(px(vals[i]));
        frame_clr = 1'b1;
        m_valid   = 1'b1;
        m_data    = px(77);
        @(negedge clk);
        checks++;
        if (m_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_m_ready: got %0b required 0", m_ready);
        end
        @(posedge clk);
        #1;
        frame_clr = 1'b0;
        m_valid   = 1'b0;
        cfg_width = CW'(2);
        repeat (4) send_beat(px(9));
        drain();
        checks++;
        if (out_q.size() !== 2) begin
            errors++;
            $display("FAIL clr_count: got %0d required 2", out_q.size());
        end else begin
            checks++;
            if (out_q[0] !== px(5) || out_q[1] !== px(9)) begin
                errors++;
                $display("FAIL clr_data: got %h %h required %h %h", out_q[0], out_q[1], px(5), px(9));
            end
        end
        out_q.delete();
    endtask

    task automatic test_reset_mid();
        do_clr();
        cfg_mode  = POOL_MAX;
        cfg_width = CW'(4);
        send_beat(px(1));
        send_beat(px(5));
        send_beat(px(2));
        send_beat(px(3));
        send_beat(px(4));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        cfg_width = CW'(2);
        repeat (4) send_beat(px(9));
        drain();
        checks++;
        if (out_q.size() !== 1) begin
            errors++;
            $display("FAIL rstmid_count: got %0d required 1", out_q.size());
        end else begin
            checks++;
            if (out_q[0] !== px(9)) begin
                errors++;
                $display("FAIL rstmid_data: got %h required %h", out_q[0], px(9));
            end
        end
        out_q.delete();
    endtask

    task automatic test_bypass();
        logic [DN*DW-1:0] exp_q[$];
        do_clr();
        cfg_mode  = POOL_BYPASS;
        cfg_width = CW'(4);
        s_ready   = 1'b1;
        tog_stop  = 1'b0;
        fork
            begin
                while (!tog_stop) begin
                    @(posedge clk);
                    #1;
                    s_ready = !s_ready;
                end
            end
            begin
                for (int k = 1; k <= 6; k++) begin
                    exp_q.push_back(beat(k));
                    send_beat(beat(k));
                    checks++;
                    if (s_valid !== 1'b1 || s_data !== beat(k)) begin
                        errors++;
                        $display("FAIL byp_latency: beat %0d valid=%0b data=%h required 1 %h",
                                 k, s_valid, s_data, beat(k));
                    end
                end
                tog_stop = 1'b1;
            end
        join
        s_ready = 1'b1;
        drain();
        checks++;
        if (out_q.size() !== 6) begin
            errors++;
            $display("FAIL byp_count: got %0d required 6", out_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (out_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL byp_data: beat %0d got %h required %h", k, out_q[k], exp_q[k]);
                end
            end
        end
        out_q.delete();
        do_clr();
        cfg_mode = 2'd3;
        send_beat(beat(10));
        checks++;
        if (s_valid !== 1'b1 || s_data !== beat(10)) begin
            errors++;
            $display("FAIL reserved_mode: valid=%0b data=%h required 1 %h", s_valid, s_data, beat(10));
        end
        drain();
        out_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_clr = 1'b0;
        s_ready   = 1'b1;
        m_valid   = 1'b0;
        m_data    = '0;
        tog_stop  = 1'b0;
        test_reset();
        test_max();
        test_avg();
        test_backpressure();
        test_odd_width();
        test_frame_clr();
        test_reset_mid();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool2x2_stream.md
# pool2x2_stream

Parametrised 2×2 / stride-2 pooling stage for the streaming feature-map pipeline.
- Consumes one pixel per beat (DN channels of DW bits, row-major) and produces one pooled pixel per 2×2 window.
- Supports max, average and bypass modes, configurable row width up to MAXW, and full ready/valid backpressure on both sides.
- Sits between the convolution/activation output and the next layer's input buffer; successor to the fixed-mode, non-backpressured max-pool stage.

## Interface
Parameters:
- DW, 8: bits per channel.
- DN, 6: channels per beat.
- MAXW, 64: maximum row width in pixels. Must be even and ≥ 2.
- SIGNED, 1: 1 = two's-complement channel data, 0 = unsigned.

Ports:
- clk  in  1  clock. Single clock domain.
- rst_n  in  1  reset: synchronous, active-low.
- cfg_width  in  $clog2(MAXW)+1  row width in pixels, 2..MAXW.
- cfg_mode  in  2  0 = bypass, 1 = max, 2 = avg, 3 = reserved (behaves as bypass).
- frame_clr  in  1  synchronous clear of the frame position.
- m_data  in  DN*DW  input pixel.
- m_valid  in  1  input valid.
- m_ready  out  1  input ready.
- s_data  out  DN*DW  pooled pixel.
- s_valid  out  1  output valid.
- s_ready  in  1  output ready.

## Operation
- Input beat accepted when m_valid && m_ready. Output beat taken when s_valid && s_ready.
- Position counters:
  - col: 0..cfg_width-1, increments per accepted beat, wraps to 0 at cfg_width-1.
  - row_ph: toggles on each col wrap.
- Bypass mode: every accepted beat is copied to the output register unchanged.
- Pooling, horizontal stage:
  - Even col: store the pixel in h_reg.
  - Odd col: h = op(h_reg, pixel), per channel.
- Pooling, line buffer:
  - MAXW/2 entries of DN*(DW+1) bits, indexed col>>1.
  - row_ph = 0: odd-col beats write h into the line buffer. No output.
  - row_ph = 1: odd-col beats compute v = op(lbuf[col>>1], h) and load v into the output register.
- Max op: per-channel signed or unsigned compare per SIGNED. The line buffer holds the max sign-/zero-extended to DW+1 bits.
- Avg op:
  - Horizontal stage: DW+1-bit sum.
  - Vertical stage: DW+2-bit sum of four pixels.
  - Result = sum >>> 2 (arithmetic shift for SIGNED, i.e. floor). Low DW bits are taken; no saturation is needed.
- Odd cfg_width: the last pixel of each row is accepted and discarded. It never touches h_reg or the line buffer.
- Odd row count: the last even row stays in the line buffer and is never emitted. It is discarded by frame_clr or overwritten by the next frame.
- frame_clr:
  - Zeroes col, row_ph and h_reg.
  - Forces m_ready = 0 that cycle.
  - Does not touch the output register; a pending s_valid beat is still delivered.
  - Line buffer contents are not cleared; they are overwritten before use.
- cfg_width and cfg_mode must only change while col = 0, row_ph = 0 (after frame_clr). Other changes are undefined.

## Timing
- Reset (rst_n low at a clk edge): s_valid = 0, s_data = 0, col = 0, row_ph = 0, h_reg = 0. Beats presented during reset are ignored.
- m_ready = !frame_clr && (!s_valid || s_ready), combinational. The same rule applies in every mode, including beats that produce no output.
- Latency:
  - Pooling: s_valid rises the cycle after the 4th pixel of a window is accepted.
  - Bypass: s_valid rises the cycle after acceptance.
- Throughput: one input beat per cycle with s_ready held high.
- While s_valid && !s_ready: s_data and s_valid are held stable, m_ready = 0, and counters freeze.
- Simultaneous output take and input accept in the same cycle: the output register reloads (or clears s_valid if the beat produces no output). There is no bubble.
- Reset mid-frame: counters and output are cleared immediately, and any partial window is lost.

## Structure
- Package pool_pkg holds:
  - mode constants POOL_BYPASS = 2'd0, POOL_MAX = 2'd1, POOL_AVG = 2'd2;
  - a width helper for cfg_width.
- Sub-module pool_pe: one-channel combiner with parameters DW and SIGNED.
  - Ports: mode, a, b (extended width), result.
  - Instantiated DN times for the horizontal stage and DN times for the vertical stage.
- Top level holds the counters, h_reg, the line buffer as a register array, the output register and the ready logic. Target size is 200–300 lines.

## Test plan
All scenarios use DW = 8, DN = 1, SIGNED = 1 unless noted.
- Max, cfg_width = 4, rows [1,5,2,3] then [4,0,9,-7] -> outputs 5, 9. Each s_valid pulse follows the 2nd and 4th beats of row 2 by 1 cycle.
- Avg, same rows -> outputs 2, 1. Rows [-1,-2] and [-3,-4] with cfg_width = 2 -> output -3 (floor of -2.5).
- Backpressure: hold s_ready = 0 for 5 cycles with an output pending -> s_data stays stable, m_ready = 0, no input beats lost. Output sequence matches the unstalled run.
- Odd width, cfg_width = 5, max, rows [1,2,3,4,99] then [5,6,7,8,99] -> outputs 6, 8. The 99s never appear.
- frame_clr after 3 beats of row 2 -> the next frame [9,9],[9,9] with cfg_width = 2 outputs exactly 9. No stale output.
- Bypass with DN = 6: beats 0x01..0x06 streamed at full rate with s_ready toggling every cycle -> identical data out, 1-cycle latency, no loss or duplication.
